// File: rtl/fetch_hazard_ctrl_pkg.sv
// Shared definitions for the IF-stage sequencer: FSM states, NOP word, control bundle.
package fetch_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STALL = 2'd3
  } state_e;

  // Canonical RISC-V NOP (addi x0, x0, 0) that the IF/ID register loads on a flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic en_pc;
    logic en_pipe;
    logic sel_jump;
    logic flush_ifid;
    logic bubble_idex;
    logic imem_req;
  } ctrl_t;

endpackage

// File: rtl/fetch_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the IF-stage sequencer.
interface fetch_hazard_ctrl_if #(
  parameter int N     = 32,
  parameter int CNT_W = 16
);
  // inputs to the sequencer
  logic             IMEM_READY;
  logic             BRANCH_TAKEN;
  logic [N-3:0]     BRANCH_TARGET;
  logic             EX_MEM_READ;
  logic [4:0]       EX_RD;
  logic [4:0]       ID_RS1;
  logic [4:0]       ID_RS2;
  logic             ID_USE_RS1;
  logic             ID_USE_RS2;
  logic             CNT_CLR;
  // outputs from the sequencer
  logic             EN_PC;
  logic             EN_PIPE_PC;
  logic             EN_PIPE_Instr;
  logic             selJump;
  logic [N-3:0]     targetAddJump;
  logic             FLUSH_IFID;
  logic             BUBBLE_IDEX;
  logic             IMEM_REQ;
  logic [CNT_W-1:0] STALL_CNT;
  logic [CNT_W-1:0] FLUSH_CNT;

  // Sequencer side
  modport master (
    input  IMEM_READY, BRANCH_TAKEN, BRANCH_TARGET, EX_MEM_READ, EX_RD,
           ID_RS1, ID_RS2, ID_USE_RS1, ID_USE_RS2, CNT_CLR,
    output EN_PC, EN_PIPE_PC, EN_PIPE_Instr, selJump, targetAddJump,
           FLUSH_IFID, BUBBLE_IDEX, IMEM_REQ, STALL_CNT, FLUSH_CNT
  );

  // Pipeline side
  modport slave (
    output IMEM_READY, BRANCH_TAKEN, BRANCH_TARGET, EX_MEM_READ, EX_RD,
           ID_RS1, ID_RS2, ID_USE_RS1, ID_USE_RS2, CNT_CLR,
    input  EN_PC, EN_PIPE_PC, EN_PIPE_Instr, selJump, targetAddJump,
           FLUSH_IFID, BUBBLE_IDEX, IMEM_REQ, STALL_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/fetch_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; used for performance readout.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] q_q;
  logic [CNT_W-1:0] q_d;

  // Next count: clear beats increment, increment stops at all-ones
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != MAX)) begin
      q_d = q_q + ONE;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// IF-stage sequencer: PC/pipe enables, redirect, flush/bubble and perf counters.
module fetch_hazard_ctrl
  import fetch_hazard_ctrl_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic                CLK,
  input  logic                RSTN,
  fetch_hazard_ctrl_if.master bus
);
  localparam int AW = N - 2;

  state_e          state_q;
  state_e          state_d;
  ctrl_t           ctrl;
  logic [AW-1:0]   target_jump;
  logic            load_use;
  logic            active;
  logic            stall_inc;
  logic            flush_inc;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Load in EX writes a register that the ID instruction actually reads
  always_comb begin
    load_use = bus.EX_MEM_READ && (bus.EX_RD != 5'd0) &&
               ((bus.ID_USE_RS1 && (bus.EX_RD == bus.ID_RS1)) ||
                (bus.ID_USE_RS2 && (bus.EX_RD == bus.ID_RS2)));
  end

  // State register; reset always lands in INIT, dropping any pending redirect
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: INIT is a fixed single cycle, otherwise branch > load-use > imem wait
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = ST_RUN;
    if (state_q != ST_INIT) begin
      if (bus.BRANCH_TAKEN) begin
        state_d = ST_RUN;
      end else if (load_use) begin
        state_d = ST_STALL;
      end else if (!bus.IMEM_READY) begin
        state_d = ST_WAIT;
      end
    end
  end

  // Output decode; INIT ignores all inputs so X on them cannot leak out
  always_comb begin
    ctrl        = '0;
    target_jump = '0;
    if (state_q == ST_INIT) begin
      ctrl.bubble_idex = 1'b1;
    end else begin
      ctrl.imem_req = 1'b1;
      if (bus.BRANCH_TAKEN) begin
        ctrl.en_pc       = 1'b1;
        ctrl.en_pipe     = 1'b1;
        ctrl.sel_jump    = 1'b1;
        ctrl.flush_ifid  = 1'b1;
        ctrl.bubble_idex = 1'b1;
        target_jump      = bus.BRANCH_TARGET;
      end else if (load_use) begin
        ctrl.bubble_idex = 1'b1;
      end else if (!bus.IMEM_READY) begin
        ctrl.en_pipe    = 1'b1;
        ctrl.flush_ifid = 1'b1;
      end else begin
        ctrl.en_pc   = 1'b1;
        ctrl.en_pipe = 1'b1;
      end
    end
  end

  // Counter qualifiers: PC held while sequencing, or a redirect taken
  always_comb begin
    active    = (state_q != ST_INIT);
    stall_inc = active && !ctrl.en_pc;
    flush_inc = active && ctrl.sel_jump;
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (RSTN),
    .clr   (bus.CNT_CLR),
    .inc   (stall_inc),
    .q     (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (RSTN),
    .clr   (bus.CNT_CLR),
    .inc   (flush_inc),
    .q     (flush_cnt)
  );

  assign bus.EN_PC         = ctrl.en_pc;
  assign bus.EN_PIPE_PC    = ctrl.en_pipe;
  assign bus.EN_PIPE_Instr = ctrl.en_pipe;
  assign bus.selJump       = ctrl.sel_jump;
  assign bus.targetAddJump = target_jump;
  assign bus.FLUSH_IFID    = ctrl.flush_ifid;
  assign bus.BUBBLE_IDEX   = ctrl.bubble_idex;
  assign bus.IMEM_REQ      = ctrl.imem_req;
  assign bus.STALL_CNT     = stall_cnt;
  assign bus.FLUSH_CNT     = flush_cnt;

endmodule
